// File: rtl/main_control_if.sv
// ----------------------------------------------------------------------------
// main_control_if
//   Memory-mapped configuration/status bus for main_control.
//   mm_write_en : write strobe, one cycle
//   mm_read_en  : read strobe, one cycle
//   mm_addr     : register address
//   mm_wdata    : write data
//   mm_rdata    : registered read data (driven by the slave)
// ----------------------------------------------------------------------------
interface main_control_if;
    logic        mm_write_en;
    logic        mm_read_en;
    logic [7:0]  mm_addr;
    logic [31:0] mm_wdata;
    logic [31:0] mm_rdata;

    modport master (
        output mm_write_en, mm_read_en, mm_addr, mm_wdata,
        input  mm_rdata
    );

    modport slave (
        input  mm_write_en, mm_read_en, mm_addr, mm_wdata,
        output mm_rdata
    );
endinterface

// File: rtl/main_control.sv
// ----------------------------------------------------------------------------
// main_control
//   Channel-selection controller for a 4-input MPEG2-TS QoS switch.
//   Selects the output stream (manual, fixed priority, or priority with
//   fallback to the first healthy channel), pulses en_reset_counter every
//   reset_timer cycles, and snapshots err_count at each pulse.
// Ports
//   clk              : system clock, rising edge
//   rstn             : asynchronous active-low reset
//   valid[3:0]       : per-channel stream present
//   err_count[31:0]  : per-channel error count, byte i = channel i
//   sync[3:0]        : per-channel TS sync locked
//   mm               : memory-mapped config/status bus (slave side)
//   mux_control[1:0] : selected channel index
//   en_reset_counter : one-cycle pulse clearing the external error counters
// Registers
//   0x00 CFG    R/W  [0] fallback, [1] manual, [3:2] manual channel,
//                    [11:4] priority (slot k at [5+2k:4+2k]), [31:12] timer
//   0x01 STATUS RO   [1:0] mux_control, [5:2] valid & sync
//   0x02 ERR    RO   err_count snapshot
// ----------------------------------------------------------------------------
module main_control #(
    parameter int unsigned ERR_THRESHOLD = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [3:0]           valid,
    input  logic [31:0]          err_count,
    input  logic [3:0]           sync,
    main_control_if.slave        mm,
    output logic [1:0]           mux_control,
    output logic                 en_reset_counter
);

    localparam logic [31:0] CFG_RESET   = 32'h0000_0E40;
    localparam logic [7:0]  ADDR_CFG    = 8'h00;
    localparam logic [7:0]  ADDR_STATUS = 8'h01;
    localparam logic [7:0]  ADDR_ERR    = 8'h02;

    logic [31:0] r_cfg;
    logic [31:0] r_rdata;
    logic [31:0] r_err_snap;
    logic [19:0] r_timer;
    logic [1:0]  r_mux;
    logic        r_pulse;

    logic        w_fallback;
    logic        w_manual;
    logic [1:0]  w_manual_chan;
    logic [7:0]  w_prio;
    logic [19:0] w_reset_timer;
    logic        w_cfg_wr;
    logic [3:0]  w_healthy;
    logic [1:0]  w_mux_next;
    logic [31:0] w_rd_value;
    logic        w_timer_hit;

    assign w_fallback    = r_cfg[0];
    assign w_manual      = r_cfg[1];
    assign w_manual_chan = r_cfg[3:2];
    assign w_prio        = r_cfg[11:4];
    assign w_reset_timer = r_cfg[31:12];
    assign w_cfg_wr      = mm.mm_write_en && (mm.mm_addr == ADDR_CFG);

    // reset_timer == 0 stops the timer, so the terminal compare is gated
    assign w_timer_hit   = (w_reset_timer != '0) && (r_timer == w_reset_timer - 20'd1);

    always_comb begin
        w_healthy = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_healthy[i] = valid[i] & sync[i] &
                           (err_count[8*i +: 8] < 8'(ERR_THRESHOLD));
        end
    end

    // Walk priority slots from highest to lowest; hold current selection
    // when fallback finds no healthy channel.
    always_comb begin
        logic       found;
        logic [1:0] slot_chan;
        w_mux_next = r_mux;
        found      = 1'b0;
        slot_chan  = '0;
        if (w_manual) begin
            w_mux_next = w_manual_chan;
        end else if (!w_fallback) begin
            w_mux_next = w_prio[1:0];
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                slot_chan = w_prio[2*k +: 2];
                if (!found && w_healthy[slot_chan]) begin
                    w_mux_next = slot_chan;
                    found      = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_rd_value = '0;
        case (mm.mm_addr)
            ADDR_CFG:    w_rd_value = r_cfg;
            ADDR_STATUS: w_rd_value = {26'd0, valid & sync, r_mux};
            ADDR_ERR:    w_rd_value = r_err_snap;
            default:     w_rd_value = '0;
        endcase
    end

    // Read data is captured from the pre-edge CFG, so a same-cycle
    // read and write of CFG returns the old value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cfg   <= CFG_RESET;
            r_rdata <= '0;
            r_mux   <= '0;
        end else begin
            if (w_cfg_wr) begin
                r_cfg <= mm.mm_wdata;
            end
            if (mm.mm_read_en) begin
                r_rdata <= w_rd_value;
            end
            r_mux <= w_mux_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_timer    <= '0;
            r_pulse    <= 1'b0;
            r_err_snap <= '0;
        end else if (w_cfg_wr) begin
            r_timer <= '0;
            r_pulse <= 1'b0;
        end else if (w_timer_hit) begin
            r_timer    <= '0;
            r_pulse    <= 1'b1;
            r_err_snap <= err_count;
        end else begin
            r_pulse <= 1'b0;
            if (w_reset_timer != '0) begin
                r_timer <= r_timer + 20'd1;
            end
        end
    end

    assign mm.mm_rdata      = r_rdata;
    assign mux_control      = r_mux;
    assign en_reset_counter = r_pulse;

endmodule

// File: tb/tb_main_control.sv
// ----------------------------------------------------------------------------
// tb_main_control
//   Self-checking bench for main_control: a table of selection vectors plus
//   hand-written sequences for register access, the reset timer and
//   asynchronous reset. Expected values go through scoreboard queues.
// ----------------------------------------------------------------------------
module tb_main_control;

    logic        clk;
    logic        rstn;
    logic [3:0]  valid;
    logic [31:0] err_count;
    logic [3:0]  sync;
    logic [1:0]  mux_control;
    logic        en_reset_counter;

    main_control_if mm_bus ();

    main_control #(.ERR_THRESHOLD(3)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .valid            (valid),
        .err_count        (err_count),
        .sync             (sync),
        .mm               (mm_bus),
        .mux_control      (mux_control),
        .en_reset_counter (en_reset_counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cfg;
        logic [3:0]  valid;
        logic [3:0]  sync;
        logic [31:0] err;
        logic [1:0]  exp_mux;
    } vec_t;

    vec_t        vecs [13];
    logic [1:0]  mux_q [$];
    logic [31:0] rd_q  [$];
    int          n_checks;
    int          n_fail;
    logic [31:0] cur_cfg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic mm_write(input logic [7:0] addr, input logic [31:0] data);
        mm_bus.mm_write_en = 1'b1;
        mm_bus.mm_addr     = addr;
        mm_bus.mm_wdata    = data;
        @(negedge clk);
        mm_bus.mm_write_en = 1'b0;
        if (addr == 8'h00) cur_cfg = data;
    endtask

    task automatic mm_read(input string name, input logic [7:0] addr, input logic [31:0] exp);
        mm_bus.mm_read_en = 1'b1;
        mm_bus.mm_addr    = addr;
        rd_q.push_back(exp);
        @(negedge clk);
        mm_bus.mm_read_en = 1'b0;
        check(name, mm_bus.mm_rdata, rd_q.pop_front());
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cur_cfg  = 32'h0000_0E40;
        rstn     = 1'b0;
        valid    = '0;
        sync     = '0;
        err_count = '0;
        mm_bus.mm_write_en = 1'b0;
        mm_bus.mm_read_en  = 1'b0;
        mm_bus.mm_addr     = '0;
        mm_bus.mm_wdata    = '0;

        //            cfg            valid    sync     err            mux
        vecs[0]  = '{32'h0000_0D21, 4'hF,    4'hF,    32'h0000_0000, 2'd2};
        vecs[1]  = '{32'h0000_0D21, 4'hF,    4'hF,    32'h0005_0000, 2'd0};
        vecs[2]  = '{32'h0000_0D21, 4'hF,    4'hF,    32'h0005_0003, 2'd1};
        vecs[3]  = '{32'h0000_0D21, 4'hF,    4'hF,    32'h0005_0002, 2'd0};
        vecs[4]  = '{32'h0000_0D21, 4'hF,    4'b1000, 32'h0000_0000, 2'd3};
        vecs[5]  = '{32'h0000_0D21, 4'hF,    4'h0,    32'h0000_0000, 2'd3};
        vecs[6]  = '{32'h0000_0D21, 4'b0111, 4'b1000, 32'h0000_0000, 2'd3};
        vecs[7]  = '{32'h0000_0E4A, 4'b1011, 4'hF,    32'h0000_0000, 2'd2};
        vecs[8]  = '{32'h0000_0E4B, 4'h0,    4'h0,    32'h0000_0000, 2'd2};
        vecs[9]  = '{32'h0000_0E10, 4'h0,    4'h0,    32'h0000_0000, 2'd1};
        vecs[10] = '{32'h0000_0E41, 4'hF,    4'hF,    32'h0000_0000, 2'd0};
        vecs[11] = '{32'h0000_0E41, 4'b1110, 4'hF,    32'h0000_0000, 2'd1};
        vecs[12] = '{32'h0000_0E41, 4'b1110, 4'hF,    32'h0000_0300, 2'd2};

        // Outputs held at reset values while rstn is low
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mux", {30'd0, mux_control}, 32'd0);
            check("rst_pulse", {31'd0, en_reset_counter}, 32'd0);
            check("rst_rdata", mm_bus.mm_rdata, 32'd0);
        end
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_mux", {30'd0, mux_control}, 32'd0);
        check("post_rst_pulse", {31'd0, en_reset_counter}, 32'd0);
        mm_read("cfg_reset", 8'h00, 32'h0000_0E40);

        // Selection vectors
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].cfg != cur_cfg) mm_write(8'h00, vecs[i].cfg);
            valid     = vecs[i].valid;
            sync      = vecs[i].sync;
            err_count = vecs[i].err;
            mux_q.push_back(vecs[i].exp_mux);
            @(negedge clk);
            check($sformatf("mux_vec%0d", i), {30'd0, mux_control}, {30'd0, mux_q.pop_front()});
        end

        // STATUS read
        mm_write(8'h00, 32'h0000_0D21);
        valid = 4'hF; sync = 4'b1000; err_count = '0;
        @(negedge clk);
        mm_read("status", 8'h01, 32'h0000_0023);

        // Unmapped read, ignored write, simultaneous read/write of CFG
        mm_read("unmapped", 8'h05, 32'h0);
        mm_write(8'h03, 32'hFFFF_FFFF);
        mm_read("cfg_after_bad_wr", 8'h00, 32'h0000_0D21);
        mm_bus.mm_write_en = 1'b1;
        mm_bus.mm_read_en  = 1'b1;
        mm_bus.mm_addr     = 8'h00;
        mm_bus.mm_wdata    = 32'h0000_0E40;
        rd_q.push_back(32'h0000_0D21);
        @(negedge clk);
        mm_bus.mm_write_en = 1'b0;
        mm_bus.mm_read_en  = 1'b0;
        cur_cfg = 32'h0000_0E40;
        check("rw_same_cycle", mm_bus.mm_rdata, rd_q.pop_front());
        mm_read("cfg_after_rw", 8'h00, 32'h0000_0E40);

        // Reset timer = 30: pulses at 30 and 60 cycles after the write
        err_count = 32'h1122_3344;
        mm_write(8'h00, {20'd30, 12'hE40});
        for (int k = 1; k <= 65; k++) begin
            @(negedge clk);
            check($sformatf("pulse30_c%0d", k), {31'd0, en_reset_counter},
                  {31'd0, (k == 30 || k == 60)});
            if (k == 40) err_count = 32'h5566_7788;
        end
        mm_read("err_snapshot", 8'h02, 32'h5566_7788);

        // Timer stopped: no pulses, snapshot frozen
        mm_write(8'h00, 32'h0000_0E40);
        err_count = 32'h0102_0304;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            check($sformatf("pulse0_c%0d", k), {31'd0, en_reset_counter}, 32'd0);
        end
        mm_read("err_frozen", 8'h02, 32'h5566_7788);

        // Timer = 1: pulse every cycle
        mm_write(8'h00, {20'd1, 12'hE40});
        check("pulse1_wr_edge", {31'd0, en_reset_counter}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("pulse1_c%0d", k), {31'd0, en_reset_counter}, 32'd1);
        end

        // Asynchronous reset mid-count
        mm_write(8'h00, {20'd30, 12'hE4E});
        @(negedge clk);
        check("manual_ch3", {30'd0, mux_control}, 32'd3);
        mm_read("cfg_before_arst", 8'h00, {20'd30, 12'hE4E});
        repeat (8) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("arst_mux", {30'd0, mux_control}, 32'd0);
        check("arst_pulse", {31'd0, en_reset_counter}, 32'd0);
        check("arst_rdata", mm_bus.mm_rdata, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        cur_cfg = 32'h0000_0E40;
        valid = '0; sync = '0;
        @(negedge clk);
        mm_read("cfg_after_arst", 8'h00, 32'h0000_0E40);
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            check($sformatf("arst_nopulse_c%0d", k), {31'd0, en_reset_counter}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
